// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and instruction memory.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: issues one instruction read per FETCH phase, latches the returned
// word for decode, and advances or redirects the PC once per WRITE phase.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  fetch_unit_if.master       imem,
  output logic [31:0]        instr_raw,
  output logic [31:0]        pc,
  output logic               fetch_done,
  output logic               misaligned
);

  localparam logic [2:0] PH_FETCH = 3'd0;
  localparam logic [2:0] PH_WRITE = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} fsm_t;

  fsm_t        fsm, fsm_next;
  logic        req_q, req_next;
  logic [31:0] addr_q, addr_next;
  logic [31:0] instr_next;
  logic        done_next;
  logic        write_prev;
  logic        pc_update;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  // PC moves only on the edge that enters WRITE, however long WRITE is held.
  assign pc_update = (state == PH_WRITE) && !write_prev;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // Next-state and next-output logic for the memory request handshake.
  always_comb begin
    fsm_next   = fsm;
    req_next   = req_q;
    addr_next  = addr_q;
    instr_next = instr_raw;
    done_next  = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (state == PH_FETCH) begin
          fsm_next  = WAIT;
          req_next  = 1'b1;
          addr_next = pc;
        end
      end
      WAIT: begin
        // Completes regardless of the core phase; a started read is never aborted.
        if (imem.imem_ack) begin
          fsm_next   = DONE;
          instr_next = imem.imem_rdata;
          req_next   = 1'b0;
          addr_next  = '0;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        if (state != PH_FETCH) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Registered request/address, latched instruction and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= 1'b0;
      addr_q     <= '0;
      instr_raw  <= '0;
      fetch_done <= 1'b0;
    end else begin
      req_q      <= req_next;
      addr_q     <= addr_next;
      instr_raw  <= instr_next;
      fetch_done <= done_next;
    end
  end

  // PC advance/redirect on WRITE entry, with sticky misaligned-target flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      write_prev <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      write_prev <= (state == PH_WRITE);
      if (pc_update) begin
        if (branch_taken) begin
          pc <= {branch_target[31:2], 2'b00};
          if (branch_target[1:0] != 2'b00) misaligned <= 1'b1;
        end else begin
          pc <= pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized phases/acks/branches checked every cycle against a flag-level model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  state = 3'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr_raw, pc;
  logic        fetch_done, misaligned;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk           (clk),
    .rst           (rst),
    .state         (state),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (bus),
    .instr_raw     (instr_raw),
    .pc            (pc),
    .fetch_done    (fetch_done),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding read at most; after a read returns, no new
  // read until the core leaves FETCH; pc steps once per WRITE entry.
  logic [31:0] m_pc = RPC, m_instr = '0, m_addr = '0, m_fetch_addr = '0;
  logic        m_req = 1'b0, m_done = 1'b0, m_mis = 1'b0;
  bit          m_pending = 0, m_served = 0, m_in_write = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RPC; m_instr = '0; m_addr = '0; m_req = 1'b0; m_done = 1'b0;
      m_mis = 1'b0; m_pending = 0; m_served = 0; m_in_write = 0;
    end else begin
      m_done = 1'b0;
      if (m_pending) begin
        if (bus.imem_ack) begin
          m_instr = bus.imem_rdata; m_pending = 0; m_served = 1; m_done = 1'b1;
        end
      end else if (m_served) begin
        if (state != 3'd0) m_served = 0;
      end else if (state == 3'd0) begin
        m_pending = 1; m_fetch_addr = m_pc;
      end
      m_req  = m_pending;
      m_addr = m_pending ? m_fetch_addr : 32'h0;
      if (state == 3'd4 && !m_in_write) begin
        if (branch_taken) begin
          m_pc = branch_target & 32'hFFFF_FFFC;
          if (branch_target % 4 != 0) m_mis = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      m_in_write = (state == 3'd4);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_req",   {31'b0, bus.imem_req}, {31'b0, m_req});
      check("m_addr",  bus.imem_addr, m_addr);
      check("m_instr", instr_raw, m_instr);
      check("m_pc",    pc, m_pc);
      check("m_done",  {31'b0, fetch_done}, {31'b0, m_done});
      check("m_mis",   {31'b0, misaligned}, {31'b0, m_mis});
    end
  end

  task automatic tick(input logic [2:0] st, input logic ack, input logic [31:0] rd,
                      input logic bt, input logic [31:0] tgt);
    state = st; bus.imem_ack = ack; bus.imem_rdata = rd;
    branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    #2;
  endtask

  task automatic ph(input logic [2:0] st);
    tick(st, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // One full instruction: fetch, ack next cycle, then DECODE..WRITE.
  task automatic instr(input logic [31:0] rd, input logic bt, input logic [31:0] tgt);
    ph(3'd0);
    tick(3'd0, 1'b1, rd, 1'b0, 32'h0);
    ph(3'd1); ph(3'd2); ph(3'd3);
    tick(3'd4, 1'b0, 32'h0, bt, tgt);
  endtask

  int done_cnt;
  logic [2:0] st;

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    #1 rst = 1'b1;
    cmp_en = 1;
    ph(3'd0); ph(3'd0);
    check("rst_pc", pc, RPC);
    check("rst_instr", instr_raw, 32'h0);
    check("rst_req", {31'b0, bus.imem_req}, 32'h0);
    rst = 1'b0;

    // Minimal-latency fetch at address 0.
    ph(3'd0);
    check("f1_req", {31'b0, bus.imem_req}, 32'h1);
    check("f1_addr", bus.imem_addr, 32'h0);
    tick(3'd0, 1'b1, 32'h00A0_0093, 1'b0, 32'h0);
    check("f1_instr", instr_raw, 32'h00A0_0093);
    check("f1_done", {31'b0, fetch_done}, 32'h1);
    check("f1_req_off", {31'b0, bus.imem_req}, 32'h0);
    ph(3'd1);
    check("f1_done_pulse", {31'b0, fetch_done}, 32'h0);
    check("f1_hold", instr_raw, 32'h00A0_0093);
    ph(3'd2); ph(3'd3); ph(3'd4);
    check("pc_step1", pc, 32'h4);

    // Ack delayed 5 cycles while the core has already moved to DECODE.
    ph(3'd0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      ph(3'd1);
      check("w5_req", {31'b0, bus.imem_req}, 32'h1);
      check("w5_addr", bus.imem_addr, 32'h4);
      done_cnt += fetch_done;
    end
    tick(3'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    done_cnt += fetch_done;
    check("w5_instr", instr_raw, 32'hDEAD_BEEF);
    tick(3'd2, 1'b1, 32'h1111_2222, 1'b0, 32'h0);
    done_cnt += fetch_done;
    check("w5_one_done", done_cnt, 32'h1);
    check("spurious_ack", instr_raw, 32'hDEAD_BEEF);
    ph(3'd3); ph(3'd4);
    check("pc_step2", pc, 32'h8);
    ph(3'd4);
    tick(3'd4, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    check("pc_hold_write", pc, 32'h8);

    // Misaligned redirect, sticky flag.
    instr(32'h1, 1'b1, 32'h0000_0102);
    check("br_pc", pc, 32'h0000_0100);
    check("br_mis", {31'b0, misaligned}, 32'h1);
    instr(32'h2, 1'b0, 32'h0);
    check("mis_sticky", {31'b0, misaligned}, 32'h1);
    check("pc_104", pc, 32'h0000_0104);

    // PC wrap.
    instr(32'h3, 1'b1, 32'hFFFF_FFFC);
    check("pc_top", pc, 32'hFFFF_FFFC);
    instr(32'h4, 1'b0, 32'h0);
    check("pc_wrap", pc, 32'h0);

    // Reset mid-WAIT, then a late ack.
    ph(3'd0); ph(3'd1);
    rst = 1'b1;
    #1;
    check("rw_req", {31'b0, bus.imem_req}, 32'h0);
    check("rw_instr", instr_raw, 32'h0);
    check("rw_pc", pc, RPC);
    check("rw_mis", {31'b0, misaligned}, 32'h0);
    ph(3'd1);
    rst = 1'b0;
    tick(3'd1, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    check("late_instr", instr_raw, 32'h0);
    check("late_done", {31'b0, fetch_done}, 32'h0);
    ph(3'd0);
    check("rf_req", {31'b0, bus.imem_req}, 32'h1);
    check("rf_addr", bus.imem_addr, RPC);

    // Randomized phases, acks, branches and occasional resets.
    st = 3'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) st = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b1;
        tick(st, 1'($urandom_range(0, 1)), $urandom, 1'b0, 32'h0);
        rst = 1'b0;
        st = 3'd0;
      end
      tick(st, ($urandom_range(0, 2) == 0), $urandom,
           ($urandom_range(0, 3) == 0), $urandom);
    end
    ph(3'd1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
